instr_seq_ctrl: RTL and testbench

Multi-cycle instruction sequencer that drives the program-counter update, instruction-register load, data-memory access and register-file write strobes of the RISC-V core. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB, handshakes with instruction and data memories, and issues exactly one `PC_en` pulse per retired instruction. It sits between the memories and the PC/datapath blocks and owns all core-level sequencing.

---
 rtl/instr_seq_ctrl.sv | 87 ++++++++
 tb/tb_instr_seq_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/instr_seq_ctrl.sv
// instr_seq_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer; define SEQ_TIMEOUT_EN for the fetch/mem wait timeout
module instr_seq_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt_req,
  output logic             IMEM_req,
  input  logic             IMEM_ready,
  input  logic [31:0]      INSTR_in,
  output logic             DMEM_req,
  output logic             DMEM_we,
  input  logic             DMEM_ready,
  output logic [31:0]      INSTR,
  output logic             IR_we,
  output logic             PC_en,
  output logic             RF_we,
  output logic             busy,
  output logic             halted,
  output logic             timeout_err,
  output logic [CNT_W-1:0] instr_count
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  state_t state, nxt;
  logic is_ld, is_st, is_br, is_sys, to;
  assign is_ld  = INSTR[6:0] == 7'b0000011;
  assign is_st  = INSTR[6:0] == 7'b0100011;
  assign is_br  = INSTR[6:0] == 7'b1100011;
  assign is_sys = INSTR[6:0] == 7'b1110011;
  assign IR_we  = state == FETCH && IMEM_ready;
`ifdef SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wcnt;
  // the wait cycle that would bring the counter to TIMEOUT aborts unless ready arrives
  assign to = wcnt == TW'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wcnt <= '0;
      timeout_err <= 1'b0;
    end else begin
      wcnt <= ((state == FETCH || state == MEM) && nxt == state) ? wcnt + 1'b1 : '0;
      if ((state == FETCH || state == MEM) && nxt == HALT) timeout_err <= 1'b1;
    end
`else
  assign to = 1'b0;
  assign timeout_err = 1'b0;
`endif
  always_comb begin
    nxt = HALT;
    case (state)
      IDLE:    nxt = (!halt_req && start) ? FETCH : IDLE;
      FETCH:   nxt = IMEM_ready ? DECODE : to ? HALT : FETCH;
      DECODE:  nxt = is_sys ? HALT : EXEC;
      EXEC:    nxt = (is_ld || is_st) ? MEM : WB;
      MEM:     nxt = DMEM_ready ? WB : to ? HALT : MEM;
      WB:      nxt = halt_req ? IDLE : FETCH;
      default: nxt = HALT;
    endcase
  end
  // outputs are registered from the next state so they track the state register exactly
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      INSTR <= '0;
      instr_count <= '0;
      IMEM_req <= 1'b0;
      DMEM_req <= 1'b0;
      DMEM_we <= 1'b0;
      PC_en <= 1'b0;
      RF_we <= 1'b0;
      busy <= 1'b0;
      halted <= 1'b0;
    end else begin
      state <= nxt;
      if (IR_we) INSTR <= INSTR_in;
      if (state == WB) instr_count <= instr_count + 1'b1;
      IMEM_req <= nxt == FETCH;
      DMEM_req <= nxt == MEM;
      DMEM_we <= nxt == MEM && is_st;
      PC_en <= nxt == WB;
      RF_we <= nxt == WB && !(is_st || is_br);
      busy <= nxt != IDLE && nxt != HALT;
      halted <= nxt == HALT;
    end
endmodule

// File: tb/tb_instr_seq_ctrl.sv
// tb_instr_seq_ctrl: directed self-checking bench for instr_seq_ctrl
module tb_instr_seq_ctrl;
  logic clk, rst_n, start, halt_req, IMEM_ready, DMEM_ready;
  logic [31:0] INSTR_in, INSTR, instr_count;
  logic IMEM_req, DMEM_req, DMEM_we, IR_we, PC_en, RF_we, busy, halted, timeout_err;
  int vecs = 0, errs = 0;

  instr_seq_ctrl #(.TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
    .IMEM_req(IMEM_req), .IMEM_ready(IMEM_ready), .INSTR_in(INSTR_in),
    .DMEM_req(DMEM_req), .DMEM_we(DMEM_we), .DMEM_ready(DMEM_ready),
    .INSTR(INSTR), .IR_we(IR_we), .PC_en(PC_en), .RF_we(RF_we),
    .busy(busy), .halted(halted), .timeout_err(timeout_err), .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; halt_req = 1'b0;
    IMEM_ready = 1'b0; DMEM_ready = 1'b0; INSTR_in = '0;
    tick(); tick();
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_halted", {31'b0, halted}, 0);
    chk("rst_imem_req", {31'b0, IMEM_req}, 0);
    chk("rst_pc_en", {31'b0, PC_en}, 0);
    chk("rst_count", instr_count, 0);
    chk("rst_instr", INSTR, 0);
    chk("rst_timeout_err", {31'b0, timeout_err}, 0);
    // addi stream: PC_en and RF_we every 4th cycle
    rst_n = 1'b1; start = 1'b1; IMEM_ready = 1'b1; INSTR_in = 32'h00000013;
    tick();
    start = 1'b0;
    chk("fetch_imem_req", {31'b0, IMEM_req}, 1);
    chk("fetch_ir_we", {31'b0, IR_we}, 1);
    chk("fetch_busy", {31'b0, busy}, 1);
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) tick();
      chk($sformatf("addi_pc_en_c%0d", c), {31'b0, PC_en}, (c % 4 == 0) ? 1 : 0);
      chk($sformatf("addi_rf_we_c%0d", c), {31'b0, RF_we}, (c % 4 == 0) ? 1 : 0);
    end
    tick();
    chk("addi_count3", instr_count, 3);
    chk("addi_refetch", {31'b0, IMEM_req}, 1);
    // load with DMEM_ready arriving in the 4th MEM cycle
    INSTR_in = 32'h00002083; DMEM_ready = 1'b0;
    tick();
    chk("ld_instr", INSTR, 32'h00002083);
    chk("ld_decode_imem_req", {31'b0, IMEM_req}, 0);
    tick(); tick();
    for (int m = 1; m <= 4; m++) begin
      chk($sformatf("ld_dmem_req_m%0d", m), {31'b0, DMEM_req}, 1);
      chk($sformatf("ld_dmem_we_m%0d", m), {31'b0, DMEM_we}, 0);
      chk($sformatf("ld_pc_en_m%0d", m), {31'b0, PC_en}, 0);
      if (m == 4) DMEM_ready = 1'b1;
      tick();
    end
    chk("ld_wb_pc_en", {31'b0, PC_en}, 1);
    chk("ld_wb_rf_we", {31'b0, RF_we}, 1);
    chk("ld_wb_dmem_req", {31'b0, DMEM_req}, 0);
    // store: DMEM_we in MEM, no RF write; stray DMEM_ready outside MEM is harmless
    INSTR_in = 32'h00112023;
    tick();
    chk("st_count4", instr_count, 4);
    DMEM_ready = 1'b1;
    tick(); tick(); tick();
    chk("st_dmem_req", {31'b0, DMEM_req}, 1);
    chk("st_dmem_we", {31'b0, DMEM_we}, 1);
    tick();
    chk("st_pc_en", {31'b0, PC_en}, 1);
    chk("st_rf_we", {31'b0, RF_we}, 0);
    chk("st_wb_dmem_we", {31'b0, DMEM_we}, 0);
    // branch: 4-cycle path, no RF write
    DMEM_ready = 1'b0; INSTR_in = 32'h00000063;
    tick(); tick(); tick();
    chk("br_exec_pc_en", {31'b0, PC_en}, 0);
    tick();
    chk("br_pc_en", {31'b0, PC_en}, 1);
    chk("br_rf_we", {31'b0, RF_we}, 0);
    chk("br_dmem_req", {31'b0, DMEM_req}, 0);
    chk("br_count5", instr_count, 5);
    // halt_req in WB returns to IDLE; halt_req beats start in IDLE
    halt_req = 1'b1;
    tick();
    chk("wbhalt_busy", {31'b0, busy}, 0);
    chk("wbhalt_imem_req", {31'b0, IMEM_req}, 0);
    chk("wbhalt_halted", {31'b0, halted}, 0);
    chk("wbhalt_count6", instr_count, 6);
    start = 1'b1;
    tick();
    chk("idle_halt_wins", {31'b0, busy}, 0);
    halt_req = 1'b0; INSTR_in = 32'h00002083;
    tick();
    start = 1'b0;
    chk("restart_imem_req", {31'b0, IMEM_req}, 1);
    // asynchronous reset in the middle of MEM
    tick(); tick(); tick();
    chk("mem_before_rst", {31'b0, DMEM_req}, 1);
    rst_n = 1'b0;
    #2;
    chk("async_rst_dmem_req", {31'b0, DMEM_req}, 0);
    chk("async_rst_count", instr_count, 0);
    chk("async_rst_busy", {31'b0, busy}, 0);
    chk("async_rst_instr", INSTR, 0);
    rst_n = 1'b1;
    // ecall halts two cycles after the fetch, later start ignored
    tick();
    INSTR_in = 32'h00000073; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("ecall_decode_pc_en", {31'b0, PC_en}, 0);
    tick();
    chk("ecall_halted", {31'b0, halted}, 1);
    chk("ecall_busy", {31'b0, busy}, 0);
    chk("ecall_pc_en", {31'b0, PC_en}, 0);
    start = 1'b1;
    tick(); tick();
    start = 1'b0;
    chk("halt_absorbing", {31'b0, halted}, 1);
    chk("halt_no_fetch", {31'b0, IMEM_req}, 0);
    chk("halt_count0", instr_count, 0);
    // fetch wait with IMEM_ready held low
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; IMEM_ready = 1'b0; INSTR_in = 32'h00000013; start = 1'b1;
    tick();
    start = 1'b0;
`ifdef SEQ_TIMEOUT_EN
    tick(); tick(); tick();
    chk("to_w4_still_fetch", {31'b0, IMEM_req}, 1);
    chk("to_w4_no_err", {31'b0, timeout_err}, 0);
    tick();
    chk("to_halted", {31'b0, halted}, 1);
    chk("to_err", {31'b0, timeout_err}, 1);
    chk("to_imem_req", {31'b0, IMEM_req}, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    IMEM_ready = 1'b1;
    tick();
    chk("to_ready_wins_halted", {31'b0, halted}, 0);
    chk("to_ready_wins_err", {31'b0, timeout_err}, 0);
    chk("to_ready_wins_busy", {31'b0, busy}, 1);
    chk("to_ready_wins_instr", INSTR, 32'h00000013);
`else
    repeat (20) tick();
    chk("wait_imem_req", {31'b0, IMEM_req}, 1);
    chk("wait_busy", {31'b0, busy}, 1);
    chk("wait_no_err", {31'b0, timeout_err}, 0);
    chk("wait_not_halted", {31'b0, halted}, 0);
    IMEM_ready = 1'b1;
    tick();
    chk("wait_decode_instr", INSTR, 32'h00000013);
    chk("wait_decode_imem_req", {31'b0, IMEM_req}, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
